multi_edge_detc: RTL and testbench
==================================

# multi_edge_detc

Parametrised, multi-channel successor to the single-bit falling-edge detector used across the interconnect utilities. Each channel runs an optional synchroniser, a stable-level glitch filter and a programmable edge detector. The detector can fire on rising edges, falling edges, both, or neither. Per channel, the block provides a one-cycle edge pulse, a sticky status bit with clear, and a saturating event counter. An aggregate interrupt output is also provided. It sits between asynchronous or noisy status lines (handshake monitors, external strobes) and the interconnect's control/status logic.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (0..4; 0 = input used directly, must already be ACLK-synchronous)
- FILTER_CYCLES, 0, consecutive cycles a new level must be stable before accepted (0..255; 0 and 1 are equivalent: no filtering)
- CNT_W, 8, width of each per-channel event counter (1..16)

- ACLK  input  1  clock, all state on rising edge
- ARESET  input  1  asynchronous, active-high reset
- sig_in  input  NUM_CH  monitored signals
- mode  input  2*NUM_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  input  NUM_CH  per-channel clear of status and counter, sampled each cycle
- level_out  output  NUM_CH  filtered level per channel
- edge_pulse  output  NUM_CH  one-cycle pulse per enabled, detected edge
- status  output  NUM_CH  sticky event flag
- evt_cnt  output  NUM_CH*CNT_W  saturating event counters, channel i at [i*CNT_W +: CNT_W]
- irq  output  1  OR of all status bits

## Operation
- Reset (ARESET=1, asynchronous): every flop clears to 0. This covers sync chains, filter counters, level_out, the previous-level register, edge_pulse, status and evt_cnt. irq=0.
- Synchroniser: the per-channel shift chain is SYNC_STAGES deep; sync_out is the last stage, or sig_in when the depth is 0.
- Filter (F = max(FILTER_CYCLES,1)): each channel has a counter of ceil(log2(F+1)) bits.
  - sync_out == level_out: counter ← 0.
  - Otherwise, if counter == F-1: level_out ← sync_out and counter ← 0.
  - Otherwise: counter ← counter+1.
  - Any return to the old level before acceptance restarts the count from 0.
- Edge detect: level_d ← level_out every cycle.
  - rise = level_out & ~level_d.
  - fall = ~level_out & level_d.
  - det[i] = (mode[2i] & rise[i]) | (mode[2i+1] & fall[i]), using mode as presented in the detect cycle.
- edge_pulse ← det (registered).
- Status: status[i] ← det[i] | (status[i] & ~clr[i]). Set wins over clear when both occur in the same cycle.
- Counter:
  - clr[i] & det[i]: evt_cnt ← 1.
  - clr[i] only: evt_cnt ← 0.
  - det[i] only: evt_cnt ← evt_cnt+1, saturating at 2^CNT_W−1 (no wrap).
- irq = |status. It is combinational from flops and therefore glitch-free.
- mode = 00: no pulse, status or count for that channel. The filter and level_out keep tracking.
- Mode change: takes effect the same cycle. An edge already present in level_out/level_d is judged against the new mode.
- Channels are fully independent; simultaneous edges on all channels are all reported in the same cycle.

## Timing
- Let edge 0 be the first ACLK edge at which the first sync stage (or the filter, if SYNC_STAGES=0) samples a new sig_in level held steady. Let S = SYNC_STAGES.
  - level_out changes after edge S+F−1.
  - edge_pulse, status and evt_cnt update after edge S+F.
  - Default (S=2, F=1): pulse is visible 3 edges after the first sampling edge.
- edge_pulse is exactly 1 cycle wide per accepted transition.
- A pulse train at sync_out with any level held for fewer than F cycles produces no level change and no events (when F ≥ 2).
- Minimum spacing between reported edges on one channel: F cycles.
- Reset release with sig_in=1: the filter sees a mismatch, and one rising event is reported after the normal latency. This is intended.
- Reset asserted mid-filter or mid-pulse: state is cleared immediately; no pulse is emitted on release unless sig_in differs from 0.

## Test plan
- NUM_CH=4, S=2, F=1, mode=01 on ch0; sig_in[0] 0→1 → edge_pulse[0] high exactly one cycle, 3 edges after the sampling edge; status[0]=1; evt_cnt ch0=1; irq=1.
- mode=11 on ch1; toggle sig_in[1] 0→1→0 with 10 cycles between → two pulses; evt_cnt ch1=2. Repeat with mode=10 → only the falling edge counts.
- F=4: 3-cycle high glitch on ch2 → no level_out change, no pulse. A 4-cycle-stable high → level_out=1 after edge S+3, pulse after edge S+4.
- CNT_W=2: 5 rising edges on ch3 → evt_cnt saturates at 3. clr[3] coincident with a detect → status stays 1, evt_cnt=1. clr alone → status=0, evt_cnt=0, irq drops when all status are 0.
- Assert ARESET mid-filter count and mid-pulse → all outputs 0 asynchronously. Release with sig_in[0]=1 → one rising event after the normal latency.
- S=0, all channels mode=01, simultaneous 0→1 on all inputs → all four pulses in the same cycle, one edge after level_out updates.

Source files
------------

// File: rtl/multi_edge_detc.sv
// multi_edge_detc: multi-channel edge detector.
// Each channel is built from four stages:
//   - an optional synchroniser,
//   - a stable-level glitch filter,
//   - a programmable rising/falling edge detector,
//   - a one-cycle pulse, a sticky status bit with clear, and a saturating event counter.
// irq is the OR of all sticky status bits.
module multi_edge_detc #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_W         = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_CH-1:0]         sig_in,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]         clr,
  output logic [NUM_CH-1:0]         level_out,
  output logic [NUM_CH-1:0]         edge_pulse,
  output logic [NUM_CH-1:0]         status,
  output logic [NUM_CH*CNT_W-1:0]   evt_cnt,
  output logic                      irq
);

  // FILTER_CYCLES of 0 and 1 both mean "accept a new level on its first sample".
  localparam int FILT_N = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int FCNT_W = $clog2(FILT_N + 1);

  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_N - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [NUM_CH-1:0]        sync_out_s;

  logic [FCNT_W-1:0]        filt_cnt_r   [NUM_CH];
  logic [FCNT_W-1:0]        filt_cnt_nxt_s [NUM_CH];

  logic [NUM_CH-1:0]        level_r;
  logic [NUM_CH-1:0]        level_nxt_s;
  logic [NUM_CH-1:0]        level_d_r;

  logic [NUM_CH-1:0]        rise_s;
  logic [NUM_CH-1:0]        fall_s;
  logic [NUM_CH-1:0]        det_s;

  logic [NUM_CH-1:0]        edge_pulse_r;
  logic [NUM_CH-1:0]        status_r;
  logic [NUM_CH-1:0]        status_nxt_s;

  logic [NUM_CH*CNT_W-1:0]  evt_cnt_r;
  logic [NUM_CH*CNT_W-1:0]  evt_cnt_nxt_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      // Input is already clock-synchronous; feed the filter directly.
      assign sync_out_s = sig_in;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_r [SYNC_STAGES];

      // Shift every channel through the synchroniser chain.
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_r[s] <= '0;
          end
        end else begin
          sync_r[0] <= sig_in;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_r[s] <= sync_r[s-1];
          end
        end
      end

      assign sync_out_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // Filter: count consecutive mismatching samples, accept after FILT_N of them.
  always_comb begin
    level_nxt_s = level_r;
    for (int c = 0; c < NUM_CH; c++) begin
      filt_cnt_nxt_s[c] = '0;
      if (sync_out_s[c] == level_r[c]) begin
        filt_cnt_nxt_s[c] = '0;
      end else if (filt_cnt_r[c] == FILT_LAST) begin
        level_nxt_s[c]    = sync_out_s[c];
        filt_cnt_nxt_s[c] = '0;
      end else begin
        filt_cnt_nxt_s[c] = filt_cnt_r[c] + FCNT_ONE;
      end
    end
  end

  // Register the filter counters, the accepted level and its one-cycle delayed copy.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        filt_cnt_r[c] <= '0;
      end
      level_r   <= '0;
      level_d_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        filt_cnt_r[c] <= filt_cnt_nxt_s[c];
      end
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
    end
  end

  // Edge qualification against the mode bits presented in the detect cycle.
  always_comb begin
    rise_s = level_r & ~level_d_r;
    fall_s = ~level_r & level_d_r;
    det_s  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      det_s[c] = (mode[2*c] & rise_s[c]) | (mode[2*c+1] & fall_s[c]);
    end
  end

  // Next status and counter values.
  // A detect in the same cycle as a clear wins: status stays set and the count restarts at 1.
  always_comb begin
    status_nxt_s  = det_s | (status_r & ~clr);
    evt_cnt_nxt_s = evt_cnt_r;
    for (int c = 0; c < NUM_CH; c++) begin
      case ({clr[c], det_s[c]})
        2'b11: begin
          evt_cnt_nxt_s[c*CNT_W +: CNT_W] = CNT_ONE;
        end
        2'b10: begin
          evt_cnt_nxt_s[c*CNT_W +: CNT_W] = '0;
        end
        2'b01: begin
          if (evt_cnt_r[c*CNT_W +: CNT_W] == CNT_MAX) begin
            evt_cnt_nxt_s[c*CNT_W +: CNT_W] = CNT_MAX;
          end else begin
            evt_cnt_nxt_s[c*CNT_W +: CNT_W] = evt_cnt_r[c*CNT_W +: CNT_W] + CNT_ONE;
          end
        end
        default: begin
          evt_cnt_nxt_s[c*CNT_W +: CNT_W] = evt_cnt_r[c*CNT_W +: CNT_W];
        end
      endcase
    end
  end

  // Register the edge pulse, the sticky status bits and the event counters.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      edge_pulse_r <= '0;
      status_r     <= '0;
      evt_cnt_r    <= '0;
    end else begin
      edge_pulse_r <= det_s;
      status_r     <= status_nxt_s;
      evt_cnt_r    <= evt_cnt_nxt_s;
    end
  end

  assign level_out  = level_r;
  assign edge_pulse = edge_pulse_r;
  assign status     = status_r;
  assign evt_cnt    = evt_cnt_r;
  // irq is derived only from flops, so it cannot glitch on input activity.
  assign irq        = |status_r;

endmodule

// File: tb/tb_multi_edge_detc.sv
// Testbench for multi_edge_detc.
// Three instances share one stimulus stream and are each compared with a behavioural model:
//   - k0: SYNC_STAGES=2, FILTER_CYCLES=0, CNT_W=8
//   - k1: SYNC_STAGES=2, FILTER_CYCLES=4, CNT_W=2
//   - k2: SYNC_STAGES=0, FILTER_CYCLES=1, CNT_W=8
module tb_multi_edge_detc;

  logic        ACLK;
  logic        ARESET;
  logic [3:0]  sig;
  logic [7:0]  mode;
  logic [3:0]  clr;

  logic [3:0]  lo0, ep0, st0, lo1, ep1, st1, lo2, ep2, st2;
  logic [31:0] ec0, ec2;
  logic [7:0]  ec1;
  logic        irq0, irq1, irq2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  multi_edge_detc #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_W(8)) dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig), .mode(mode), .clr(clr),
    .level_out(lo0), .edge_pulse(ep0), .status(st0), .evt_cnt(ec0), .irq(irq0));

  multi_edge_detc #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_W(2)) dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig), .mode(mode), .clr(clr),
    .level_out(lo1), .edge_pulse(ep1), .status(st1), .evt_cnt(ec1), .irq(irq1));

  multi_edge_detc #(.NUM_CH(4), .SYNC_STAGES(0), .FILTER_CYCLES(1), .CNT_W(8)) dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .sig_in(sig), .mode(mode), .clr(clr),
    .level_out(lo2), .edge_pulse(ep2), .status(st2), .evt_cnt(ec2), .irq(irq2));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- instance parameters as seen by the model ----------------
  function automatic int s_of(int k);
    return (k == 2) ? 0 : 2;
  endfunction

  function automatic int f_of(int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic int max_of(int k);
    return (k == 1) ? 3 : 255;
  endfunction

  // ---------------- DUT output access ----------------
  function automatic int dut_lvl(int k);
    case (k)
      0:       return int'(lo0);
      1:       return int'(lo1);
      default: return int'(lo2);
    endcase
  endfunction

  function automatic int dut_pls(int k);
    case (k)
      0:       return int'(ep0);
      1:       return int'(ep1);
      default: return int'(ep2);
    endcase
  endfunction

  function automatic int dut_sts(int k);
    case (k)
      0:       return int'(st0);
      1:       return int'(st1);
      default: return int'(st2);
    endcase
  endfunction

  function automatic int dut_irq(int k);
    case (k)
      0:       return int'(irq0);
      1:       return int'(irq1);
      default: return int'(irq2);
    endcase
  endfunction

  function automatic int dut_cnt(int k, int c);
    case (k)
      0:       return int'(ec0[c*8 +: 8]);
      1:       return int'(ec1[c*2 +: 2]);
      default: return int'(ec2[c*8 +: 8]);
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // A new level is accepted once the last F filter-input samples all differ from the current level.
  // Filter-input samples are sig_in samples delayed by S clock edges.
  bit m_hist [3][4][8];   // m_hist[k][c][j] = sig_in sampled j edges ago
  bit m_lvl  [3][4];
  bit m_rise [3][4];
  bit m_fall [3][4];
  bit m_pls  [3][4];
  bit m_sts  [3][4];
  int m_cnt  [3][4];

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < 8; j++) m_hist[k][c][j] = 1'b0;
        m_lvl[k][c]  = 1'b0;
        m_rise[k][c] = 1'b0;
        m_fall[k][c] = 1'b0;
        m_pls[k][c]  = 1'b0;
        m_sts[k][c]  = 1'b0;
        m_cnt[k][c]  = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        bit d;
        bit all_new;

        // Decide whether an enabled edge was seen in the previous level change.
        d = (mode[2*c] && m_rise[k][c]) || (mode[2*c+1] && m_fall[k][c]);
        m_pls[k][c] = d;
        m_sts[k][c] = d || (m_sts[k][c] && !clr[c]);
        if (clr[c] && d)      m_cnt[k][c] = 1;
        else if (clr[c])      m_cnt[k][c] = 0;
        else if (d)           m_cnt[k][c] = (m_cnt[k][c] < max_of(k)) ? m_cnt[k][c] + 1 : max_of(k);

        // Record this edge's sample, then apply the stable-window acceptance rule.
        for (int j = 7; j > 0; j--) m_hist[k][c][j] = m_hist[k][c][j-1];
        m_hist[k][c][0] = sig[c];
        all_new = 1'b1;
        for (int j = 0; j < f_of(k); j++) begin
          if (m_hist[k][c][s_of(k)+j] == m_lvl[k][c]) all_new = 1'b0;
        end
        m_rise[k][c] = 1'b0;
        m_fall[k][c] = 1'b0;
        if (all_new) begin
          m_lvl[k][c]  = !m_lvl[k][c];
          m_rise[k][c] = m_lvl[k][c];
          m_fall[k][c] = !m_lvl[k][c];
        end
      end
    end
  endtask

  function automatic int m_vec_lvl(int k);
    int r = 0;
    for (int c = 0; c < 4; c++) if (m_lvl[k][c]) r = r | (1 << c);
    return r;
  endfunction

  function automatic int m_vec_pls(int k);
    int r = 0;
    for (int c = 0; c < 4; c++) if (m_pls[k][c]) r = r | (1 << c);
    return r;
  endfunction

  function automatic int m_vec_sts(int k);
    int r = 0;
    for (int c = 0; c < 4; c++) if (m_sts[k][c]) r = r | (1 << c);
    return r;
  endfunction

  // Model advances on every clock edge and clears on reset.
  initial begin
    model_clear();
    forever begin
      @(posedge ACLK or posedge ARESET);
      if (ARESET) model_clear();
      else        model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int k, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s k%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
  endtask

  // Compare every instance against the model on each falling edge.
  initial begin
    forever begin
      @(negedge ACLK);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          chk("level_out", k, dut_lvl(k), m_vec_lvl(k));
          chk("edge_pulse", k, dut_pls(k), m_vec_pls(k));
          chk("status", k, dut_sts(k), m_vec_sts(k));
          chk("irq", k, dut_irq(k), (m_vec_sts(k) != 0) ? 1 : 0);
          for (int c = 0; c < 4; c++) chk("evt_cnt", k, dut_cnt(k, c), m_cnt[k][c]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_lvl"}, k, dut_lvl(k), 0);
      chk({nm, "_pls"}, k, dut_pls(k), 0);
      chk({nm, "_sts"}, k, dut_sts(k), 0);
      chk({nm, "_irq"}, k, dut_irq(k), 0);
      for (int c = 0; c < 4; c++) chk({nm, "_cnt"}, k, dut_cnt(k, c), 0);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    ARESET = 1'b0;
    sig    = 4'h0;
    mode   = 8'h00;
    clr    = 4'h0;
    #1 ARESET = 1'b1;
    #1 chk_all_zero("reset");
    chk_en = 1'b1;
    cyc(3);
    ARESET = 1'b0;
    cyc(10);

    // Rising edge on ch0, default latency of 3 edges.
    mode = 8'b00_00_00_01;
    sig[0] = 1'b1;
    cyc(3);
    chk("lat_lvl0", 0, dut_lvl(0) & 1, 1);
    chk("lat_pls0_early", 0, dut_pls(0) & 1, 0);
    cyc(1);
    chk("lat_pls0", 0, dut_pls(0) & 1, 1);
    chk("lat_sts0", 0, dut_sts(0) & 1, 1);
    chk("lat_cnt0", 0, dut_cnt(0, 0), 1);
    chk("lat_irq0", 0, dut_irq(0), 1);
    cyc(1);
    chk("pls0_width", 0, dut_pls(0) & 1, 0);
    cyc(5);

    // Both edges on ch1, then falling edges only.
    mode = 8'b00_00_11_01;
    sig[1] = 1'b1; cyc(10);
    sig[1] = 1'b0; cyc(10);
    chk("both_cnt1", 0, dut_cnt(0, 1), 2);
    mode = 8'b00_00_10_01;
    sig[1] = 1'b1; cyc(10);
    sig[1] = 1'b0; cyc(10);
    chk("fall_cnt1", 0, dut_cnt(0, 1), 3);

    // Glitch shorter than the filter window, then a stable high, on ch2.
    mode = 8'b00_01_10_01;
    sig[2] = 1'b1; cyc(3);
    sig[2] = 1'b0; cyc(12);
    chk("glitch_lvl2", 1, dut_lvl(1) & 4, 0);
    chk("glitch_sts2", 1, dut_sts(1) & 4, 0);
    sig[2] = 1'b1;
    cyc(5);
    chk("filt_lvl2_early", 1, dut_lvl(1) & 4, 0);
    cyc(1);
    chk("filt_lvl2", 1, dut_lvl(1) & 4, 4);
    chk("filt_pls2_early", 1, dut_pls(1) & 4, 0);
    cyc(1);
    chk("filt_pls2", 1, dut_pls(1) & 4, 4);
    sig[2] = 1'b0; cyc(12);

    // Saturation on ch3, then clear coincident with a detect, then a plain clear.
    clr = 4'hF; cyc(1); clr = 4'h0;
    mode = 8'b01_01_10_01;
    for (int i = 0; i < 5; i++) begin
      sig[3] = 1'b1; cyc(8);
      sig[3] = 1'b0; cyc(8);
    end
    chk("sat_cnt3", 1, dut_cnt(1, 3), 3);
    chk("nosat_cnt3", 0, dut_cnt(0, 3), 5);
    sig[3] = 1'b1;
    cyc(6);
    clr = 4'b1000;
    cyc(1);
    clr = 4'h0;
    chk("clrdet_sts3", 1, dut_sts(1) & 8, 8);
    chk("clrdet_cnt3", 1, dut_cnt(1, 3), 1);
    chk("clronly_sts3", 0, dut_sts(0) & 8, 0);
    chk("clronly_cnt3", 0, dut_cnt(0, 3), 0);
    cyc(4);
    clr = 4'hF;
    cyc(1);
    clr = 4'h0;
    chk("clr_irq", 0, dut_irq(0), 0);
    chk("clr_irq", 1, dut_irq(1), 0);
    chk("clr_cnt3", 1, dut_cnt(1, 3), 0);
    cyc(4);

    // Reset while k0 pulses and k1 is mid-filter; release with sig_in[0]=1.
    sig = 4'b0000; cyc(10);
    sig = 4'b0001;
    cyc(4);
    chk("midpulse", 0, dut_pls(0) & 1, 1);
    #2 ARESET = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    cyc(3);
    chk("rel_pls_early", 0, dut_pls(0) & 1, 0);
    cyc(1);
    chk("rel_pls", 0, dut_pls(0) & 1, 1);
    chk("rel_cnt", 0, dut_cnt(0, 0), 1);
    cyc(10);
    chk("rel_once", 0, dut_cnt(0, 0), 1);
    chk("rel_sts", 0, dut_sts(0), 1);

    // Simultaneous rising edges on all channels with no synchroniser.
    sig = 4'h0; mode = 8'b01_01_01_01; cyc(10);
    sig = 4'hF;
    cyc(1);
    chk("s0_lvl", 2, dut_lvl(2), 15);
    chk("s0_pls_early", 2, dut_pls(2), 0);
    cyc(1);
    chk("s0_pls", 2, dut_pls(2), 15);
    cyc(12);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
